gpr_dump: RTL and testbench

Post-run readout engine for the single-cycle MIPS core. It is the reader end of the register-file debug path. On a start pulse it walks a range of GPR indices through a combinational read port. Each register value goes out on a valid/ready stream, and the unit flags whether one designated register matches an expected value, which is the hardware equivalent of the bench pass/fail check on R16. It sits beside the register file and drives a spare read port while the core is held.

---
 rtl/gpr_dump.sv | 138 +++++++++++++
 tb/tb_gpr_dump.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_dump.sv
// Post-run GPR readout: walks FIRST_REG..LAST_REG through a spare register-file read port,
// streams each value out on a valid/ready channel and flags whether CHECK_REG holds exp_value.
module gpr_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter int unsigned CHECK_REG = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] exp_value,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done,
  output logic        match
);

  localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
  localparam logic [4:0] LastIdx  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StFin
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        valid_q, valid_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        match_q, match_d;

  logic handshake;
  logic at_check;

  assign handshake = valid_q & dump_ready;
  // Widened compare so a CHECK_REG outside 0..31 can never alias onto a real index.
  assign at_check  = ({27'd0, ptr_q} == CHECK_REG);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    match_d = match_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          ptr_d   = FirstIdx;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          match_d = 1'b0;
        end
      end
      StLoad: begin
        data_d  = rd_data;
        idx_d   = ptr_q;
        valid_d = 1'b1;
        state_d = StSend;
        if (at_check) begin
          match_d = (rd_data == exp_value);
        end
      end
      StSend: begin
        if (handshake) begin
          valid_d = 1'b0;
          // Range end is tested before the increment, so ptr never wraps past 31.
          if (ptr_q == LastIdx) begin
            state_d = StFin;
          end else begin
            ptr_d   = ptr_q + 5'd1;
            state_d = StLoad;
          end
        end
      end
      StFin: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ptr_d   = FirstIdx;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= FirstIdx;
      valid_q <= 1'b0;
      idx_q   <= 5'd0;
      data_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign rd_addr    = ptr_q;
  assign dump_valid = valid_q;
  assign dump_idx   = idx_q;
  assign dump_data  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign match      = match_q;

  // A stalled beat must not change under the consumer.
  assert property (@(posedge clk) disable iff (rst)
    (valid_q && !dump_ready) |=> (valid_q && $stable(idx_q) && $stable(data_q)));

  assert property (@(posedge clk) disable iff (rst) busy_q == (state_q != StIdle));

  assert property (@(posedge clk) disable iff (rst) valid_q |-> (state_q == StSend));

endmodule

// File: tb/tb_gpr_dump.sv
// Bench for gpr_dump: a transaction-level model predicts every output each cycle for a
// default-range instance and a single-register instance, plus directed literal checks.
module tb_gpr_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, dump_ready;
  logic [31:0] exp_value;
  logic [31:0] gpr [32];

  logic [4:0]  rd_addr1, idx1, rd_addr2, idx2;
  logic [31:0] rd_data1, data1, rd_data2, data2;
  logic        valid1, busy1, done1, match1;
  logic        valid2, busy2, done2, match2;

  assign rd_data1 = gpr[rd_addr1];
  assign rd_data2 = gpr[rd_addr2];

  gpr_dump u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .exp_value (exp_value),
    .rd_addr   (rd_addr1),
    .rd_data   (rd_data1),
    .dump_valid(valid1),
    .dump_ready(dump_ready),
    .dump_idx  (idx1),
    .dump_data (data1),
    .busy      (busy1),
    .done      (done1),
    .match     (match1)
  );

  gpr_dump #(
    .FIRST_REG(5),
    .LAST_REG (5),
    .CHECK_REG(16)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .exp_value (exp_value),
    .rd_addr   (rd_addr2),
    .rd_data   (rd_data2),
    .dump_valid(valid2),
    .dump_ready(dump_ready),
    .dump_idx  (idx2),
    .dump_data (data2),
    .busy      (busy2),
    .done      (done2),
    .match     (match2)
  );

  // Model state: the visible beat plus a pending "next beat appears" / "dump ends" event.
  typedef struct packed {
    logic        valid;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        match;
    logic        load_pend;
    logic        fin_pend;
    logic [4:0]  next_idx;
  } mstate_t;

  mstate_t m1, m2;

  function automatic mstate_t model_next(input mstate_t s, input logic r, input logic st,
                                         input logic rdy, input logic [31:0] exp,
                                         input int unsigned first, input int unsigned last,
                                         input int unsigned chk);
    mstate_t n;
    n = s;
    if (r) begin
      n = '0;
      return n;
    end
    if (s.load_pend) begin
      n.load_pend = 1'b0;
      n.valid     = 1'b1;
      n.idx       = s.next_idx;
      n.data      = gpr[s.next_idx];
      if (32'(s.next_idx) == chk) n.match = (gpr[s.next_idx] == exp);
    end
    if (s.fin_pend) begin
      n.fin_pend = 1'b0;
      n.busy     = 1'b0;
      n.done     = 1'b1;
    end
    if (s.valid && rdy) begin
      n.valid = 1'b0;
      if (32'(s.idx) == last) begin
        n.fin_pend = 1'b1;
      end else begin
        n.load_pend = 1'b1;
        n.next_idx  = s.idx + 5'd1;
      end
    end
    if (!s.busy && st) begin
      n.busy      = 1'b1;
      n.done      = 1'b0;
      n.match     = 1'b0;
      n.load_pend = 1'b1;
      n.next_idx  = 5'(first);
    end
    return n;
  endfunction

  function automatic logic [4:0] model_addr(input mstate_t s, input int unsigned first);
    if (!s.busy) return 5'(first);
    if (s.load_pend) return s.next_idx;
    return s.idx;
  endfunction

  always @(posedge clk) begin
    m1 <= model_next(m1, rst, start, dump_ready, exp_value, 0, 31, 16);
    m2 <= model_next(m2, rst, start, dump_ready, exp_value, 5, 5, 16);
  end

  int hs1 = 0;
  int hs2 = 0;
  always @(posedge clk) begin
    if (valid1 && dump_ready) hs1 <= hs1 + 1;
    if (valid2 && dump_ready) hs2 <= hs2 + 1;
  end

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    if (chk_en) begin
      check("dut1 cycle {valid,idx,data,busy,done,match,rd_addr}",
            {18'd0, valid1, idx1, data1, busy1, done1, match1, rd_addr1},
            {18'd0, m1.valid, m1.idx, m1.data, m1.busy, m1.done, m1.match, model_addr(m1, 0)});
      check("dut2 cycle {valid,idx,data,busy,done,match,rd_addr}",
            {18'd0, valid2, idx2, data2, busy2, done2, match2, rd_addr2},
            {18'd0, m2.valid, m2.idx, m2.data, m2.busy, m2.done, m2.match, model_addr(m2, 5)});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      compare_cycle();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int c;
    c = 0;
    while (busy1 && c < maxc) begin
      tick(1);
      c++;
    end
    check("dump finished within cycle budget", {63'd0, busy1}, 64'd0);
  endtask

  int h0, h20;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    dump_ready = 1'b1;
    exp_value  = 32'h110;
    for (int i = 0; i < 32; i++) gpr[i] = 32'h100 + 32'(i);
    repeat (2) @(posedge clk);
    #2;
    rst    = 1'b0;
    chk_en = 1'b1;
    compare_cycle();
    check("reset valid/busy/done/match", {60'd0, valid1, busy1, done1, match1}, 64'd0);
    check("reset dump_idx", 64'(idx1), 64'd0);
    check("reset dump_data", 64'(data1), 64'd0);
    check("reset rd_addr dut1", 64'(rd_addr1), 64'd0);
    check("reset rd_addr dut2", 64'(rd_addr2), 64'd5);

    // Full default dump, ready high: beat k accepted at E(2k+2), done after E65.
    h0  = hs1;
    h20 = hs2;
    pulse_start();
    check("busy after start edge", {63'd0, busy1}, 64'd1);
    tick(1);
    check("beat0 valid after E1", {63'd0, valid1}, 64'd1);
    check("beat0 idx", 64'(idx1), 64'd0);
    check("beat0 data", 64'(data1), 64'h100);
    check("single-reg beat idx", 64'(idx2), 64'd5);
    check("single-reg beat data", 64'(data2), 64'h105);
    tick(63);
    check("done still low after E64", {63'd0, done1}, 64'd0);
    tick(1);
    check("done after E65", {62'd0, done1, busy1}, 64'b10);
    check("match R16=0x110", {63'd0, match1}, 64'd1);
    check("beats in full dump", 64'(hs1 - h0), 64'd32);
    check("beats in single-reg dump", 64'(hs2 - h20), 64'd1);
    check("single-reg done, no match", {62'd0, done2, match2}, 64'b10);

    // Backpressure on beat 3 for five cycles.
    h0 = hs1;
    pulse_start();
    tick(7);
    check("beat3 presented", 64'(idx1), 64'd3);
    dump_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("stalled beat3 {valid,idx,data}", {26'd0, valid1, idx1, data1},
            {26'd0, 1'b1, 5'd3, 32'h103});
    end
    dump_ready = 1'b1;
    wait_idle(200);
    check("beats with backpressure", 64'(hs1 - h0), 64'd32);

    // Match pass then fail; second start clears sticky flags.
    gpr[16]   = 32'hAB;
    exp_value = 32'hAB;
    pulse_start();
    wait_idle(200);
    check("match pass {done,match}", {62'd0, done1, match1}, 64'b11);
    exp_value = 32'hAC;
    pulse_start();
    check("start clears {done,match}", {62'd0, done1, match1}, 64'b00);
    wait_idle(200);
    check("match fail {done,match}", {62'd0, done1, match1}, 64'b10);

    // start during beat 10 is ignored.
    h0 = hs1;
    pulse_start();
    tick(21);
    check("beat10 presented", 64'(idx1), 64'd10);
    pulse_start();
    check("no restart after mid-dump start", {58'd0, busy1, idx1}, {58'd0, 1'b1, 5'd10});
    wait_idle(200);
    check("beats with ignored start", 64'(hs1 - h0), 64'd32);

    // Reset during beat 7, then a clean dump.
    pulse_start();
    tick(15);
    check("beat7 presented", {58'd0, valid1, idx1}, {58'd0, 1'b1, 5'd7});
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid-dump reset {valid,busy,done,match,idx,rd_addr}",
          {50'd0, valid1, busy1, done1, match1, idx1, rd_addr1}, 64'd0);
    check("mid-dump reset data", 64'(data1), 64'd0);
    h0 = hs1;
    pulse_start();
    tick(1);
    check("clean dump restarts at idx0", {26'd0, valid1, idx1, data1},
          {26'd0, 1'b1, 5'd0, 32'h100});
    wait_idle(200);
    check("beats after reset", 64'(hs1 - h0), 64'd32);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      dump_ready = ($urandom_range(0, 3) != 0);
      start      = ($urandom_range(0, 19) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) gpr[$urandom_range(0, 31)] = $urandom;
      if ($urandom_range(0, 1) == 0) exp_value = gpr[16];
      else exp_value = $urandom;
      tick(1);
    end
    rst        = 1'b0;
    start      = 1'b0;
    dump_ready = 1'b1;
    tick(2);
    wait_idle(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
